// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller port bundle: ID-stage operand info in,
// pipeline control and statistics out.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_two_src;
    logic              id_wb_en;
    logic              id_mem_read;
    logic [REG_AW-1:0] id_dest;
    logic              branch_taken;
    logic              mem_stall;
    logic              hazard;
    logic              freeze;
    logic              flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src,
        output id_wb_en, id_mem_read, id_dest,
        output branch_taken, mem_stall,
        input  hazard, freeze, flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src,
        input  id_wb_en, id_mem_read, id_dest,
        input  branch_taken, mem_stall,
        output hazard, freeze, flush, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// RAW hazard detection with an in-flight destination scoreboard.
// Entry 0 is the EXE instruction, entry DEPTH-1 the oldest.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 4,
    parameter int DEPTH  = 2,
    parameter int FWD_EN = 0,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst,
    pipe_hazard_ctrl_if.slave bus
);

    typedef struct packed {
        logic              vld;
        logic              wb_en;
        logic              mem_rd;
        logic [REG_AW-1:0] dest;
    } sb_entry_t;

    sb_entry_t        sb_q [DEPTH];
    sb_entry_t        sb_d [DEPTH];
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    logic hazard;
    logic flush;
    logic issue;
    logic raw;
    logic match;

    // Compare ID sources against every live entry; a taken branch
    // discards the ID instruction so it can never raise a hazard.
    always_comb begin
        raw   = 1'b0;
        match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            match = sb_q[k].vld & sb_q[k].wb_en &
                    ((sb_q[k].dest == bus.id_src1) |
                     (bus.id_two_src &
                      (sb_q[k].dest == bus.id_src2)));
            if (FWD_EN == 0) begin
                raw = raw | match;
            end else if (k == 0) begin
                raw = raw | (match & sb_q[k].mem_rd);
            end
        end
        hazard = bus.id_valid & raw & ~bus.branch_taken;
        flush  = bus.branch_taken & ~bus.mem_stall;
        issue  = bus.id_valid & ~hazard & ~bus.branch_taken;
    end

    // Advance the scoreboard one stage unless memory holds the pipe;
    // a stalled or discarded ID slot enters EXE as a bubble.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            sb_d[k] = sb_q[k];
        end
        if (!bus.mem_stall) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0].vld    = issue;
            sb_d[0].wb_en  = bus.id_wb_en;
            sb_d[0].mem_rd = bus.id_mem_read;
            sb_d[0].dest   = bus.id_dest;
        end
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State registers; reset drops every in-flight entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= '0;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= sb_d[k];
            end
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.hazard    = hazard;
    assign bus.freeze    = hazard | bus.mem_stall;
    assign bus.flush     = flush;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: two controllers (no forwarding / forwarding)
// share one ID stimulus stream; each task checks its own scenario.
module tb_pipe_hazard_ctrl;

    localparam int AW = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic          id_valid, id_two_src, id_wb_en, id_mem_read;
    logic [AW-1:0] id_src1, id_src2, id_dest;
    logic          br, ms;

    pipe_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) if0 ();
    pipe_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) if1 ();

    assign if0.id_valid     = id_valid;
    assign if0.id_src1      = id_src1;
    assign if0.id_src2      = id_src2;
    assign if0.id_two_src   = id_two_src;
    assign if0.id_wb_en     = id_wb_en;
    assign if0.id_mem_read  = id_mem_read;
    assign if0.id_dest      = id_dest;
    assign if0.branch_taken = br;
    assign if0.mem_stall    = ms;
    assign if1.id_valid     = id_valid;
    assign if1.id_src1      = id_src1;
    assign if1.id_src2      = id_src2;
    assign if1.id_two_src   = id_two_src;
    assign if1.id_wb_en     = id_wb_en;
    assign if1.id_mem_read  = id_mem_read;
    assign if1.id_dest      = id_dest;
    assign if1.branch_taken = br;
    assign if1.mem_stall    = ms;

    pipe_hazard_ctrl #(.REG_AW(AW), .DEPTH(2), .FWD_EN(0), .CNT_W(CW))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    pipe_hazard_ctrl #(.REG_AW(AW), .DEPTH(2), .FWD_EN(1), .CNT_W(CW))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_id(input logic v, input logic [AW-1:0] s1,
                          input logic [AW-1:0] s2, input logic two,
                          input logic wb, input logic mrd,
                          input logic [AW-1:0] d);
        id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
        id_wb_en = wb; id_mem_read = mrd; id_dest = d;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_id(0, 0, 0, 0, 0, 0, 0);
        br = 0; ms = 0;
        rst = 1'b0;
        next_cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        set_id(0, 0, 0, 0, 0, 0, 0);
        br = 0; ms = 0;
        #2;
        n_tests++; if (if0.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d exp 0", if0.stall_cnt); end
        n_tests++; if (if0.flush_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_flush_cnt: got %0d exp 0", if0.flush_cnt); end
        n_tests++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL rst_hazard: got %b exp 0", if0.hazard); end
        n_tests++; if (if0.flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b exp 0", if0.flush); end
        n_tests++; if (if0.freeze !== 1'b0) begin n_fail++; $display("FAIL rst_freeze: got %b exp 0", if0.freeze); end
        next_cyc();
        rst = 1'b1;
    endtask

    task automatic test_raw_nofwd();
        set_id(1, 0, 0, 0, 1, 0, 1);
        @(negedge clk);
        n_tests++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL raw_issue_hz: got %b exp 0", if0.hazard); end
        next_cyc();
        set_id(1, 1, 0, 0, 1, 0, 2);
        @(negedge clk);
        n_tests++; if (if0.hazard !== 1'b1) begin n_fail++; $display("FAIL raw_c1_hz: got %b exp 1", if0.hazard); end
        n_tests++; if (if0.freeze !== 1'b1) begin n_fail++; $display("FAIL raw_c1_frz: got %b exp 1", if0.freeze); end
        n_tests++; if (if1.hazard !== 1'b0) begin n_fail++; $display("FAIL raw_fwd_hz: got %b exp 0", if1.hazard); end
        next_cyc();
        @(negedge clk);
        n_tests++; if (if0.hazard !== 1'b1) begin n_fail++; $display("FAIL raw_c2_hz: got %b exp 1", if0.hazard); end
        n_tests++; if (if0.stall_cnt !== 4'd1) begin n_fail++; $display("FAIL raw_c2_cnt: got %0d exp 1", if0.stall_cnt); end
        next_cyc();
        @(negedge clk);
        n_tests++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL raw_c3_hz: got %b exp 0", if0.hazard); end
        n_tests++; if (if0.freeze !== 1'b0) begin n_fail++; $display("FAIL raw_c3_frz: got %b exp 0", if0.freeze); end
        n_tests++; if (if0.stall_cnt !== 4'd2) begin n_fail++; $display("FAIL raw_cnt: got %0d exp 2", if0.stall_cnt); end
        do_reset();
    endtask

    task automatic test_load_use();
        set_id(1, 0, 0, 0, 1, 1, 3);
        next_cyc();
        set_id(1, 0, 3, 1, 1, 0, 4);
        @(negedge clk);
        n_tests++; if (if1.hazard !== 1'b1) begin n_fail++; $display("FAIL ldu_c1_hz: got %b exp 1", if1.hazard); end
        next_cyc();
        @(negedge clk);
        n_tests++; if (if1.hazard !== 1'b0) begin n_fail++; $display("FAIL ldu_c2_hz: got %b exp 0", if1.hazard); end
        n_tests++; if (if1.stall_cnt !== 4'd1) begin n_fail++; $display("FAIL ldu_cnt: got %0d exp 1", if1.stall_cnt); end
        do_reset();
        set_id(1, 0, 0, 0, 1, 0, 3);
        next_cyc();
        set_id(1, 0, 3, 1, 1, 0, 4);
        @(negedge clk);
        n_tests++; if (if1.hazard !== 1'b0) begin n_fail++; $display("FAIL alu_fwd_hz: got %b exp 0", if1.hazard); end
        n_tests++; if (if0.hazard !== 1'b1) begin n_fail++; $display("FAIL alu_nofwd_hz: got %b exp 1", if0.hazard); end
        do_reset();
    endtask

    task automatic test_two_src();
        set_id(1, 0, 0, 0, 1, 0, 1);
        next_cyc();
        set_id(1, 7, 1, 0, 1, 0, 2);
        @(negedge clk);
        n_tests++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL two_src0_hz: got %b exp 0", if0.hazard); end
        #1 id_two_src = 1'b1;
        #1;
        n_tests++; if (if0.hazard !== 1'b1) begin n_fail++; $display("FAIL two_src1_hz: got %b exp 1", if0.hazard); end
        #1 id_valid = 1'b0;
        #1;
        n_tests++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL invalid_hz: got %b exp 0", if0.hazard); end
        do_reset();
    endtask

    task automatic test_branch();
        set_id(1, 0, 0, 0, 1, 0, 2);
        next_cyc();
        set_id(1, 2, 0, 0, 1, 0, 6);
        br = 1'b1;
        @(negedge clk);
        n_tests++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL br_hz: got %b exp 0", if0.hazard); end
        n_tests++; if (if0.flush !== 1'b1) begin n_fail++; $display("FAIL br_flush: got %b exp 1", if0.flush); end
        next_cyc();
        br = 1'b0;
        set_id(1, 6, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++; if (if0.flush_cnt !== 4'd1) begin n_fail++; $display("FAIL br_fcnt: got %0d exp 1", if0.flush_cnt); end
        n_tests++; if (if0.flush !== 1'b0) begin n_fail++; $display("FAIL br_flush_off: got %b exp 0", if0.flush); end
        n_tests++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL br_bubble_hz: got %b exp 0", if0.hazard); end
        n_tests++; if (if0.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL br_scnt: got %0d exp 0", if0.stall_cnt); end
        do_reset();
    endtask

    task automatic test_mem_stall();
        set_id(1, 0, 0, 0, 1, 0, 5);
        next_cyc();
        set_id(1, 5, 0, 0, 1, 0, 6);
        ms = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (if0.freeze !== 1'b1) begin n_fail++; $display("FAIL ms_frz[%0d]: got %b exp 1", i, if0.freeze); end
            n_tests++; if (if0.hazard !== 1'b1) begin n_fail++; $display("FAIL ms_hz[%0d]: got %b exp 1", i, if0.hazard); end
            next_cyc();
        end
        ms = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++; if (if0.hazard !== 1'b1) begin n_fail++; $display("FAIL ms_post_hz[%0d]: got %b exp 1", i, if0.hazard); end
            next_cyc();
        end
        @(negedge clk);
        n_tests++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL ms_clear_hz: got %b exp 0", if0.hazard); end
        n_tests++; if (if0.stall_cnt !== 4'd5) begin n_fail++; $display("FAIL ms_scnt: got %0d exp 5", if0.stall_cnt); end
        #1 ms = 1'b1; br = 1'b1;
        #1;
        n_tests++; if (if0.flush !== 1'b0) begin n_fail++; $display("FAIL ms_defer_flush: got %b exp 0", if0.flush); end
        n_tests++; if (if0.freeze !== 1'b1) begin n_fail++; $display("FAIL ms_defer_frz: got %b exp 1", if0.freeze); end
        #1 ms = 1'b0;
        #1;
        n_tests++; if (if0.flush !== 1'b1) begin n_fail++; $display("FAIL ms_release_flush: got %b exp 1", if0.flush); end
        br = 1'b0;
        do_reset();
    endtask

    task automatic test_saturation();
        set_id(1, 0, 0, 0, 1, 0, 5);
        next_cyc();
        set_id(1, 5, 0, 0, 1, 0, 6);
        ms = 1'b1;
        repeat (21) next_cyc();
        @(negedge clk);
        n_tests++; if (if0.stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_scnt: got %0d exp 15", if0.stall_cnt); end
        #1 rst = 1'b0;
        #1;
        n_tests++; if (if0.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL async_scnt: got %0d exp 0", if0.stall_cnt); end
        n_tests++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL async_hz: got %b exp 0", if0.hazard); end
        ms = 1'b0;
        next_cyc();
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (if0.hazard !== 1'b0) begin n_fail++; $display("FAIL post_rst_hz: got %b exp 0", if0.hazard); end
        n_tests++; if (if0.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL post_rst_scnt: got %0d exp 0", if0.stall_cnt); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_raw_nofwd();
        test_load_use();
        test_two_src();
        test_branch();
        test_mem_stall();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 4, register-address width.
REQ-002 SHALL have parameter DEPTH, default 2, number of in-flight stages tracked between ID and WB (EXE, MEM); legal 1..4.
REQ-003 SHALL have parameter FWD_EN, default 0; 0 = no forwarding (stall on any RAW), 1 = forwarding present (stall on load-use only).
REQ-004 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 id_valid  in  1  ID stage holds a real instruction.
REQ-008 id_src1  in  REG_AW  first source register (Rn).
REQ-009 id_src2  in  REG_AW  second source register (Rm/Rd).
REQ-010 id_two_src  in  1  id_src2 is read.
REQ-011 id_wb_en  in  1  ID instruction writes a register.
REQ-012 id_mem_read  in  1  ID instruction is a load.
REQ-013 id_dest  in  REG_AW  ID instruction destination.
REQ-014 branch_taken  in  1  branch resolved taken in EXE this cycle.
REQ-015 mem_stall  in  1  memory stage not ready; whole pipe holds.
REQ-016 hazard  out  1  RAW hazard on ID instruction (combinational).
REQ-017 freeze  out  1  hold PC and IF/ID register (combinational).
REQ-018 flush  out  1  clear IF/ID and ID/EXE registers (combinational).
REQ-019 stall_cnt  out  CNT_W  cycles with hazard=1 (registered).
REQ-020 flush_cnt  out  CNT_W  cycles with flush=1 (registered).

Function
REQ-021 SHALL keep a scoreboard of DEPTH entries {vld, wb_en, mem_rd, dest}; entry 0 = instruction in EXE, entry DEPTH-1 = oldest (MEM side).
REQ-022 Issue condition: issue = id_valid & ~hazard & ~branch_taken.
REQ-023 When mem_stall=0, every rising edge SHALL shift entries k -> k+1 (entry DEPTH-1 retires) and load entry 0 with {issue, id_wb_en, id_mem_read, id_dest}; when issue=0 entry 0 SHALL load a bubble (vld=0).
REQ-024 When mem_stall=1, scoreboard SHALL hold unchanged.
REQ-025 match(s,k) = entry k vld & wb_en & dest==s; src2 compared only when id_two_src=1; nothing compared when id_valid=0.
REQ-026 FWD_EN=0: hazard SHALL be 1 when match on src1 or src2 against any entry 0..DEPTH-1.
REQ-027 FWD_EN=1: hazard SHALL be 1 only when match against entry 0 with entry 0 mem_rd=1 (load-use, one bubble).
REQ-028 branch_taken=1 SHALL force hazard=0 (ID instruction is discarded) and flush=1 in the same cycle.
REQ-029 freeze SHALL equal hazard | mem_stall; flush SHALL equal branch_taken & ~mem_stall (a flush during mem_stall is deferred until mem_stall falls, branch_taken held by EXE).
REQ-030 stall_cnt SHALL increment on each edge where hazard=1; flush_cnt on each edge where flush=1; both saturate at all-ones, no wrap.
REQ-031 A hazard SHALL clear without external action once the producing entry retires (FWD_EN=0) or moves out of entry 0 (FWD_EN=1); zero-latency RAW through the register file write-back is excluded (written at WB negedge).
REQ-032 Simultaneous mem_stall and hazard: freeze=1, no bubble inserted, scoreboard held.

Reset
REQ-033 rst=0 SHALL asynchronously clear all scoreboard vld bits, stall_cnt and flush_cnt to 0; hazard=0 and flush=0 follow while inputs idle.
REQ-034 Reset asserted mid-stall SHALL drop all in-flight entries; first cycle after release has no hazard from pre-reset instructions.

Verification
REQ-035 FWD_EN=0, DEPTH=2: issue ADD R1 (wb_en), next ID reads src1=R1 -> hazard=1, freeze=1 for 2 cycles, then 0; stall_cnt=2.
REQ-036 FWD_EN=1: issue LDR R3 (mem_read), next ID reads src2=R3 with two_src=1 -> hazard=1 exactly 1 cycle; same with ADD R3 -> hazard never 1.
REQ-037 id_two_src=0, src2=R1 matching in-flight R1 -> hazard=0.
REQ-038 branch_taken=1 while ID has RAW on R2 -> hazard=0, flush=1, entry 0 becomes bubble; flush_cnt=1.
REQ-039 mem_stall=1 for 3 cycles with ADD R5 in entry 0 and ID reading R5 (FWD_EN=0) -> freeze=1 all 3 cycles, scoreboard unchanged, hazard resolves 2 cycles after mem_stall falls.
REQ-040 Drive hazard 2^CNT_W+5 cycles (CNT_W=4: 21) -> stall_cnt=15 saturated; rst low mid-run -> counters 0 immediately, no clock needed.
